risc_core_p: RTL

RISC_CORE_P -- requirements
Module: risc_core_p

---
 rtl/risc_core_p.sv | 131 +++++++++++++
 1 files changed

// File: rtl/risc_core_p.sv
// Two-word-fetch accumulator core: F0/F1 fetch opcode and operand, EX executes, MEM does data access.
// Optional RISC_CORE_P_CARRY_EN adds c_flag (ADD/ADDR carry, SUB borrow) and JC (opcode 0, reg 1).
module risc_core_p #(
  parameter int DW   = 8,
  parameter int AW   = 8,
  parameter int NREG = 16
) (
  input  logic          clk,
  input  logic          rst,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic [AW-1:0] pc_out,
  output logic [DW-1:0] acc_out,
  output logic [3:0]    ins_out,
  output logic [2:0]    state_out,
  output logic          halted
`ifdef RISC_CORE_P_CARRY_EN
  ,
  output logic          c_flag
`endif
);

  localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [2:0] {
    F0   = 3'd0,
    F1   = 3'd1,
    EX   = 3'd2,
    MEM  = 3'd3,
    HALT = 3'd4
  } state_t;

  state_t        state;
  logic [AW-1:0] pc;
  logic [DW-1:0] acc;
  logic [DW-1:0] operand;
  logic [3:0]    opcode;
  logic [RW-1:0] ridx;
  logic [DW-1:0] regs [NREG];

  // Request drops combinationally with rst so an in-flight transfer is abandoned at once.
  assign mem_req   = ((state == F0) || (state == F1) || (state == MEM)) && !rst;
  assign mem_we    = (state == MEM) && (opcode == 4'h2);
  assign mem_addr  = (state == MEM) ? operand[AW-1:0] : pc;
  assign mem_wdata = acc;

  assign pc_out    = pc;
  assign acc_out   = acc;
  assign ins_out   = opcode;
  assign state_out = state;
  assign halted    = (state == HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= F0;
      pc      <= '0;
      acc     <= '0;
      operand <= '0;
      opcode  <= '0;
      ridx    <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
`ifdef RISC_CORE_P_CARRY_EN
      c_flag  <= 1'b0;
`endif
    end else begin
      case (state)
        F0: if (mem_ack) begin
          opcode <= mem_rdata[DW-1:DW-4];
          ridx   <= mem_rdata[RW-1:0];
          pc     <= pc + AW'(1);
          state  <= F1;
        end
        F1: if (mem_ack) begin
          operand <= mem_rdata;
          pc      <= pc + AW'(1);
          state   <= EX;
        end
        EX: begin
          state <= F0;
          case (opcode)
`ifdef RISC_CORE_P_CARRY_EN
            4'h0: if ((ridx == RW'(1)) && c_flag) pc <= operand[AW-1:0];
`endif
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: state <= MEM;
            4'h8: acc <= regs[ridx];
            4'h9: regs[ridx] <= acc;
`ifdef RISC_CORE_P_CARRY_EN
            4'hA: {c_flag, acc} <= {1'b0, acc} + {1'b0, regs[ridx]};
`else
            4'hA: acc <= acc + regs[ridx];
`endif
            4'hB: acc <= operand;
            4'hC: pc <= operand[AW-1:0];
            4'hD: if (acc == '0) pc <= operand[AW-1:0];
            4'hE: begin
              regs[NREG-1] <= DW'(pc);
              pc           <= operand[AW-1:0];
            end
            4'hF: state <= HALT;
            default: ;
          endcase
        end
        MEM: if (mem_ack) begin
          state <= F0;
          case (opcode)
            4'h1: acc <= mem_rdata;
`ifdef RISC_CORE_P_CARRY_EN
            // Bit DW of the widened difference is the borrow.
            4'h3: {c_flag, acc} <= {1'b0, acc} + {1'b0, mem_rdata};
            4'h4: {c_flag, acc} <= {1'b0, acc} - {1'b0, mem_rdata};
`else
            4'h3: acc <= acc + mem_rdata;
            4'h4: acc <= acc - mem_rdata;
`endif
            4'h5: acc <= acc & mem_rdata;
            4'h6: acc <= acc | mem_rdata;
            4'h7: acc <= acc ^ mem_rdata;
            default: ;
          endcase
        end
        HALT: state <= HALT;
        default: state <= F0;
      endcase
    end
  end

endmodule
